// File: rtl/mccomp_dbg_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mccomp_dbg_pkg
// Shared definitions for the mccomp bring-up/debug sequencer:
//   - state_e    : session phase (IDLE -> LOAD -> HOLD -> RUN -> DUMP -> DONE)
//   - REG_SEL_W  : width of the CPU register-file select / dump index
//   - DEF_*      : default parameter values used by the top and sub-module
// ---------------------------------------------------------------------------
package mccomp_dbg_pkg;

    localparam int REG_SEL_W    = 5;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_HOLD_CYC = 4;
    localparam int DEF_RUN_CYC  = 1000;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DUMP,
        DONE
    } state_e;

endpackage

// File: rtl/mccomp_dbg_dump.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mccomp_dbg_dump
// Register-file sweep for the DUMP phase. Drives reg_sel, captures the
// combinational reg_data one cycle later and presents it on a valid/ready
// stream. Entries leave at most once every two cycles because reg_sel only
// advances on a handshake and the new value is captured on the next cycle.
// Ports:
//   clk, rstn     clock, async active-low reset
//   clr           clears the sweep back to register 0 (new session)
//   en            high while the top is in DUMP
//   reg_data      register value for the current reg_sel
//   dump_ready    consumer ready
//   reg_sel       register select to the CPU
//   dump_valid    entry valid
//   dump_idx      register index of the entry
//   dump_data     captured register value
//   last_accept   final register (NUM_REGS-1) handshaken this cycle
// ---------------------------------------------------------------------------
module mccomp_dbg_dump
    import mccomp_dbg_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DATA_W-1:0]    reg_data,
    input  logic                 dump_ready,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 dump_valid,
    output logic [REG_SEL_W-1:0] dump_idx,
    output logic [DATA_W-1:0]    dump_data,
    output logic                 last_accept
);

    localparam logic [REG_SEL_W-1:0] LAST_IDX = REG_SEL_W'(NUM_REGS - 1);

    logic [REG_SEL_W-1:0] reg_sel_q, reg_sel_d;
    logic                 valid_q, valid_d;
    logic [REG_SEL_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]    data_q, data_d;

    // When no entry is pending, reg_sel has been stable for a full cycle, so
    // reg_data is captured. A pending entry holds until the consumer takes it.
    always_comb begin
        reg_sel_d   = reg_sel_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        data_d      = data_q;
        last_accept = 1'b0;
        if (clr) begin
            reg_sel_d = '0;
            valid_d   = 1'b0;
        end else if (en) begin
            if (!valid_q) begin
                valid_d = 1'b1;
                idx_d   = reg_sel_q;
                data_d  = reg_data;
            end else if (dump_ready) begin
                valid_d = 1'b0;
                if (idx_q == LAST_IDX) begin
                    last_accept = 1'b1;
                end else begin
                    reg_sel_d = reg_sel_q + REG_SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_sel_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            reg_sel_q <= reg_sel_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    assign reg_sel    = reg_sel_q;
    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;

endmodule

// File: rtl/mccomp_boot_dbg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mccomp_boot_dbg
// Bring-up sequencer for the multi-cycle MIPS computer: streams a program
// image into memory, holds the CPU in reset, runs it until halt or a cycle
// budget, freezes it and dumps the register file on a valid/ready stream.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   start                           begin a session (honoured in IDLE/DONE)
//   ld_valid/ld_ready/ld_data/ld_last   program image load stream
//   mem_we/mem_addr/mem_wdata       memory write port (LOAD only)
//   cpu_rstn/cpu_clk_en/cpu_halt    CPU reset, clock enable, halt status
//   reg_sel/reg_data                register-file read port
//   dump_valid/dump_ready/dump_idx/dump_data   register dump stream
//   done/timeout/load_ovf           session status flags
// ---------------------------------------------------------------------------
module mccomp_boot_dbg
    import mccomp_dbg_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int RUN_CYC  = DEF_RUN_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic                 ld_last,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 cpu_rstn,
    output logic                 cpu_clk_en,
    input  logic                 cpu_halt,
    output logic [REG_SEL_W-1:0] reg_sel,
    input  logic [DATA_W-1:0]    reg_data,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [REG_SEL_W-1:0] dump_idx,
    output logic [DATA_W-1:0]    dump_data,
    output logic                 done,
    output logic                 timeout,
    output logic                 load_ovf
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              load_ovf_q, load_ovf_d;

    logic start_ok, ld_acc, last_slot, hold_end, run_end, dump_last;

    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign ld_acc    = (state_q == LOAD) && ld_valid;
    assign last_slot = &idx_q;
    assign hold_end  = (cnt_q == CNT_W'(HOLD_CYC - 1));
    assign run_end   = (cnt_q == CNT_W'(RUN_CYC - 1));

    // Session phase sequencing; halt is checked before the budget so that a
    // halt on the final budget cycle counts as a clean halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = LOAD;
            LOAD:       if (ld_acc && (ld_last || last_slot)) state_d = HOLD;
            HOLD:       if (hold_end) state_d = RUN;
            RUN:        if (cpu_halt || run_end) state_d = DUMP;
            DUMP:       if (dump_last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Load write path, phase counter and status flags. The write is issued
    // one cycle after acceptance from registered copies of the load word.
    always_comb begin
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        timeout_d   = timeout_q;
        load_ovf_d  = load_ovf_q;
        cnt_d       = '0;
        if (start_ok) begin
            idx_d      = '0;
            mem_addr_d = '0;
            timeout_d  = 1'b0;
            load_ovf_d = 1'b0;
        end
        if (ld_acc) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q;
            mem_wdata_d = ld_data;
            idx_d       = idx_q + ADDR_W'(1);
            if (last_slot && !ld_last) load_ovf_d = 1'b1;
        end
        case (state_q)
            HOLD: cnt_d = hold_end ? '0 : cnt_q + CNT_W'(1);
            RUN: begin
                if (cpu_halt) begin
                    timeout_d = 1'b0;
                end else if (run_end) begin
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Phase-decoded CPU control and handshake outputs.
    always_comb begin
        ld_ready   = 1'b0;
        cpu_rstn   = 1'b0;
        cpu_clk_en = 1'b0;
        done       = 1'b0;
        case (state_q)
            LOAD: ld_ready = 1'b1;
            HOLD: cpu_clk_en = 1'b1;
            RUN: begin
                cpu_rstn   = 1'b1;
                cpu_clk_en = 1'b1;
            end
            DUMP: cpu_rstn = 1'b1;
            DONE: begin
                cpu_rstn = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            load_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            load_ovf_q  <= load_ovf_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign timeout   = timeout_q;
    assign load_ovf  = load_ovf_q;

    mccomp_dbg_dump #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_dump (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (start_ok),
        .en          (state_q == DUMP),
        .reg_data    (reg_data),
        .dump_ready  (dump_ready),
        .reg_sel     (reg_sel),
        .dump_valid  (dump_valid),
        .dump_idx    (dump_idx),
        .dump_data   (dump_data),
        .last_accept (dump_last)
    );

endmodule

// File: tb/tb_mccomp_boot_dbg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mccomp_boot_dbg
// Self-checking bench for mccomp_boot_dbg (ADDR_W=3 so the overflow path is
// reachable). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mccomp_boot_dbg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int HOLD_CYC = 4;
    localparam int RUN_CYC  = 1000;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rstn;
    logic              cpu_clk_en;
    logic              cpu_halt = 1'b0;
    logic [4:0]        reg_sel;
    logic [DATA_W-1:0] reg_data;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [4:0]        dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic              done;
    logic              timeout;
    logic              load_ovf;

    int nCompared   = 0;
    int nMismatched = 0;

    mccomp_boot_dbg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .HOLD_CYC (HOLD_CYC),
        .RUN_CYC  (RUN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rstn   (cpu_rstn),
        .cpu_clk_en (cpu_clk_en),
        .cpu_halt   (cpu_halt),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .done       (done),
        .timeout    (timeout),
        .load_ovf   (load_ovf)
    );

    always #5 clk = ~clk;

    // Register file model: r[i] = i * 0x11.
    assign reg_data = 32'(reg_sel) * 32'h11;

    typedef struct {
        logic        start;
        logic        ldValid;
        logic        ldLast;
        logic [31:0] ldData;
        logic        expLdReady;
        logic        expMemWe;
        logic [2:0]  expMemAddr;
        logic [31:0] expMemWdata;
        logic        expCpuRstn;
        logic        expClkEn;
        logic        expOvf;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Wait for the falling edge, then drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic st, input logic vld, input logic last,
                                 input logic [31:0] data, input logic halt, input logic rdy);
        @(negedge clk);
        start      = st;
        ld_valid   = vld;
        ld_last    = last;
        ld_data    = data;
        cpu_halt   = halt;
        dump_ready = rdy;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ld_ready"}, ld_ready, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_cpu_rstn"}, cpu_rstn, 0);
        checkOutput({tag, "_cpu_clk_en"}, cpu_clk_en, 0);
        checkOutput({tag, "_reg_sel"}, reg_sel, 0);
        checkOutput({tag, "_dump_valid"}, dump_valid, 0);
        checkOutput({tag, "_dump_idx"}, dump_idx, 0);
        checkOutput({tag, "_dump_data"}, dump_data, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_load_ovf"}, load_ovf, 0);
    endtask

    // Wait (bounded) for the first RUN cycle; returns on that falling edge.
    task automatic waitRun();
        bit seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (cpu_rstn === 1'b1 && cpu_clk_en === 1'b1) seen = 1;
        end
        checkOutput("wait_run", seen, 1);
    endtask

    // Drain the dump stream from the cycle after DUMP entry, scoreboarding
    // order, data, stall stability and the two-cycle spacing.
    task automatic runDump(input bit stallPattern, input logic expTimeout);
        int          expIdx = 0;
        int          cyc = 0;
        bit          prevStall = 0;
        bit          prevAccept = 0;
        logic [4:0]  prevIdx = '0;
        logic [31:0] prevData = '0;
        logic [31:0] cycBits;
        while (expIdx < NUM_REGS && cyc < 400) begin
            cyc++;
            cycBits = 32'(cyc);
            applyStimulus(0, 0, 0, 0, 0, stallPattern ? cycBits[1] : 1'b1);
            checkOutput("dump_clk_en", cpu_clk_en, 0);
            if (prevStall) begin
                checkOutput("dump_stall_valid", dump_valid, 1);
                checkOutput("dump_stall_idx", dump_idx, prevIdx);
                checkOutput("dump_stall_data", dump_data, prevData);
            end
            if (prevAccept) checkOutput("dump_gap", dump_valid, 0);
            prevStall  = 0;
            prevAccept = 0;
            if (dump_valid === 1'b1) begin
                checkOutput("dump_idx", dump_idx, expIdx);
                checkOutput("dump_data", dump_data, expIdx * 32'h11);
                prevIdx  = dump_idx;
                prevData = dump_data;
                if (dump_ready) begin
                    expIdx++;
                    prevAccept = 1;
                end else begin
                    prevStall = 1;
                end
            end
        end
        checkOutput("dump_count", expIdx, NUM_REGS);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("done_after_dump", done, 1);
        checkOutput("done_dump_valid", dump_valid, 0);
        checkOutput("done_cpu_rstn", cpu_rstn, 1);
        checkOutput("done_clk_en", cpu_clk_en, 0);
        checkOutput("done_timeout", timeout, expTimeout);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int runCycles;
        int writes;
        int sent;

        // Load of four words with one bubble, then the reset hold window and
        // the first RUN cycle.
        //            st vld lst data          rdy we adr wdata        rst en ovf
        vecs[0]  = '{1, 0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 0};
        vecs[1]  = '{0, 1, 0, 32'h20080005,  1, 0, 0, 32'h0,        0, 0, 0};
        vecs[2]  = '{0, 1, 0, 32'h20090003,  1, 1, 0, 32'h20080005, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,         1, 1, 1, 32'h20090003, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 32'h01095020,  1, 0, 1, 32'h20090003, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 32'h0000000C,  1, 1, 2, 32'h01095020, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,         0, 1, 3, 32'h0000000C, 0, 1, 0};
        vecs[7]  = '{0, 0, 0, 32'h0,         0, 0, 3, 32'h0000000C, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 32'h0,         0, 0, 3, 32'h0000000C, 0, 1, 0};
        vecs[9]  = '{0, 0, 0, 32'h0,         0, 0, 3, 32'h0000000C, 0, 1, 0};
        vecs[10] = '{0, 0, 0, 32'h0,         0, 0, 3, 32'h0000000C, 1, 1, 0};

        #12;
        checkResetValues("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].start, vecs[i].ldValid, vecs[i].ldLast, vecs[i].ldData, 0, 0);
            checkOutput($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].expLdReady);
            checkOutput($sformatf("v%0d_mem_we", i), mem_we, vecs[i].expMemWe);
            checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].expMemAddr);
            checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].expMemWdata);
            checkOutput($sformatf("v%0d_cpu_rstn", i), cpu_rstn, vecs[i].expCpuRstn);
            checkOutput($sformatf("v%0d_cpu_clk_en", i), cpu_clk_en, vecs[i].expClkEn);
            checkOutput($sformatf("v%0d_load_ovf", i), load_ovf, vecs[i].expOvf);
        end

        // Halt raised on RUN cycle 10.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 0, 0, 0, (k == 10), 0);
            checkOutput("halt_run_rstn", cpu_rstn, 1);
            checkOutput("halt_run_clk_en", cpu_clk_en, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("halt_freeze_clk_en", cpu_clk_en, 0);
        checkOutput("halt_cpu_rstn", cpu_rstn, 1);
        checkOutput("halt_timeout", timeout, 0);
        checkOutput("halt_first_valid", dump_valid, 0);
        runDump(1, 0);

        // Budget expiry: no halt, count RUN cycles with the CPU out of reset.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h1111, 0, 0);
        checkOutput("s2_done_cleared", done, 0);
        checkOutput("s2_reg_sel_cleared", reg_sel, 0);
        runCycles = 0;
        for (int c = 0; c < 1200; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (cpu_rstn === 1'b1 && cpu_clk_en === 1'b1) runCycles++;
            else if (runCycles > 0) break;
        end
        checkOutput("run_cycles", runCycles, RUN_CYC);
        checkOutput("budget_timeout", timeout, 1);
        checkOutput("budget_clk_en", cpu_clk_en, 0);
        runDump(0, 1);

        // Halt on the very cycle the budget expires: halt wins.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h2222, 0, 0);
        checkOutput("s3_timeout_cleared", timeout, 0);
        waitRun();
        for (int k = 1; k < RUN_CYC; k++) begin
            applyStimulus(0, 0, 0, 0, (k == RUN_CYC - 1), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("tie_clk_en", cpu_clk_en, 0);
        checkOutput("tie_timeout", timeout, 0);
        runDump(0, 0);

        // Overflow: 2^ADDR_W words without ld_last, valid held beyond that.
        applyStimulus(1, 0, 0, 0, 0, 0);
        writes = 0;
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(0, (c < 10), 0, 32'hB0 + 32'(sent), 0, 0);
            if (ld_valid && ld_ready) sent++;
            if (mem_we === 1'b1) begin
                checkOutput("ovf_addr", mem_addr, writes);
                checkOutput("ovf_wdata", mem_wdata, 32'hB0 + 32'(writes));
                writes++;
            end
            if (c == 8) begin
                checkOutput("ovf_hold_rstn", cpu_rstn, 0);
                checkOutput("ovf_hold_clk_en", cpu_clk_en, 1);
                checkOutput("ovf_hold_ld_ready", ld_ready, 0);
            end
        end
        checkOutput("ovf_writes", writes, 8);
        checkOutput("ovf_flag", load_ovf, 1);

        // start during RUN is ignored; then async reset mid-RUN.
        waitRun();
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ignored_start_ld_ready", ld_ready, 0);
        checkOutput("ignored_start_cpu_rstn", cpu_rstn, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkResetValues("midrun");
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("post_reset_idle_done", done, 0);
        applyStimulus(0, 1, 1, 32'h0000ABCD, 0, 0);
        checkOutput("reload_ld_ready", ld_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("reload_mem_we", mem_we, 1);
        checkOutput("reload_mem_addr", mem_addr, 0);
        checkOutput("reload_mem_wdata", mem_wdata, 32'h0000ABCD);
        checkOutput("reload_load_ovf", load_ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
